// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   Timestamps rising edges of a synchronous event strobe against a free-running
//   counter. For each event it also records the modular interval since the
//   previous event. Entries {stamp, delta, first} are queued in a small FIFO and
//   drained over a valid/ready interface.
//
// Ports
//   clk        rising-edge clock, shared with the counter
//   reset      asynchronous active-low reset
//   count      counter value, synchronous to clk
//   enable     arm capture (low disarms)
//   event_in   event level; a 0->1 transition is an event
//   ovf_clr    single-cycle pulse that clears overflow
//   out_valid  head entry valid
//   out_ready  consumer accepts the head entry
//   out_stamp  captured count of the head entry
//   out_delta  interval of the head entry
//   out_first  head entry is the first event since arming
//   level      entries held, 0..DEPTH
//   overflow   sticky: an event was dropped because the FIFO was full
module count_capture_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LVLW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic             event_in,
    input  logic             ovf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_stamp,
    output logic [WIDTH-1:0] out_delta,
    output logic             out_first,
    output logic [LVLW-1:0]  level,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_RUNNING  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ev_prev;
    logic [WIDTH-1:0] r_last_stamp;
    logic [WIDTH-1:0] r_mem_stamp [DEPTH];
    logic [WIDTH-1:0] r_mem_delta [DEPTH];
    logic             r_mem_first [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LVLW-1:0]  r_level;
    logic             r_overflow;

    logic             w_event;
    logic             w_capture;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_delta;
    logic             w_first;
    logic [PW-1:0]    w_show_ptr;

    assign w_event   = event_in & ~r_ev_prev;
    // An event counts only once armed; it is still processed in the cycle
    // enable falls because the decision uses the current state.
    assign w_capture = w_event & (r_state != S_DISARMED);
    assign w_pop     = (r_level != '0) & out_ready;
    assign w_full    = (r_level == LVLW'(DEPTH));
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;
    // Unsigned subtraction truncated to WIDTH handles counter wrap.
    assign w_delta   = (r_state == S_RUNNING) ? (count - r_last_stamp) : '0;
    assign w_first   = (r_state == S_ARMED);

    // When empty, point at the slot most recently popped so the data outputs
    // hold their last values. That slot cannot be rewritten while empty since
    // the write pointer sits at the read pointer.
    assign w_show_ptr = out_valid ? r_rd_ptr : (r_rd_ptr - PW'(1));

    assign out_valid = (r_level != '0);
    assign out_stamp = r_mem_stamp[w_show_ptr];
    assign out_delta = r_mem_delta[w_show_ptr];
    assign out_first = r_mem_first[w_show_ptr];
    assign level     = r_level;
    assign overflow  = r_overflow;

    // Capture state machine and interval tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_DISARMED;
            r_ev_prev    <= 1'b0;
            r_last_stamp <= '0;
        end else begin
            r_ev_prev <= event_in;
            // last_stamp follows every processed event, dropped ones included,
            // so the next delta measures from the most recent real event.
            if (w_capture) r_last_stamp <= count;
            case (r_state)
                S_DISARMED: if (enable) r_state <= S_ARMED;
                S_ARMED: begin
                    if (!enable)      r_state <= S_DISARMED;
                    else if (w_event) r_state <= S_RUNNING;
                end
                S_RUNNING:  if (!enable) r_state <= S_DISARMED;
                default:    r_state <= S_DISARMED;
            endcase
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_stamp[i] <= '0;
                r_mem_delta[i] <= '0;
                r_mem_first[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem_stamp[r_wr_ptr] <= count;
                r_mem_delta[r_wr_ptr] <= w_delta;
                r_mem_first[r_wr_ptr] <= w_first;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVLW'(1);
                2'b01:   r_level <= r_level - LVLW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
        else if (ovf_clr) r_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
module tb_count_capture_fifo;

    localparam int W = 16;
    localparam int D = 4;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] count = '0;
    logic         enable = 1'b0;
    logic         event_in = 1'b0;
    logic         ovf_clr = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_stamp;
    logic [W-1:0] out_delta;
    logic         out_first;
    logic [L-1:0] level;
    logic         overflow;

    count_capture_fifo #(.WIDTH(W), .DEPTH(D), .LVLW(L)) dut (
        .clk(clk), .reset(reset), .count(count), .enable(enable),
        .event_in(event_in), .ovf_clr(ovf_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_stamp(out_stamp), .out_delta(out_delta),
        .out_first(out_first), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of entries plus a few abstract flags.
    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] d;
        logic         f;
    } ent_t;

    ent_t         mq[$];
    bit           m_prev, m_active, m_seen, m_ovf;
    logic [W-1:0] m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = 0; m_active = 0; m_seen = 0; m_ovf = 0; m_last = '0;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit   ev, pop, drop;
        ent_t e;
        ev   = event_in && !m_prev;
        pop  = (mq.size() != 0) && out_ready;
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (m_active && ev) begin
            e.s = count;
            e.f = !m_seen;
            e.d = m_seen ? W'(count - m_last) : '0;
            if (mq.size() < D) mq.push_back(e);
            else drop = 1;
            m_last = count;
            m_seen = 1;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (!m_active) begin
            if (enable) begin m_active = 1; m_seen = 0; end
        end else if (!enable) begin
            m_active = 0; m_seen = 0;
        end
        m_prev = event_in;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk({tag, ".stamp"}, 32'(out_stamp), 32'(mq[0].s));
            chk({tag, ".delta"}, 32'(out_delta), 32'(mq[0].d));
            chk({tag, ".first"}, 32'(out_first), 32'(mq[0].f));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    task automatic ev_hi(input logic [W-1:0] c);
        event_in = 1'b1; count = c; step();
    endtask

    task automatic ev_lo();
        event_in = 1'b0; count = count + 16'd1; step();
    endtask

    initial begin
        model_reset();
        #1;
        // Reset state
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.stamp", 32'(out_stamp), 32'd0);
        chk("rst.delta", 32'(out_delta), 32'd0);
        chk("rst.first", 32'(out_first), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic capture with 1-cycle latency
        enable = 1'b1; out_ready = 1'b1;
        step();
        ev_hi(16'h0010);
        chk("t1.valid", 32'(out_valid), 32'd1);
        chk("t1.stamp", 32'(out_stamp), 32'h0010);
        chk("t1.delta", 32'(out_delta), 32'h0000);
        chk("t1.first", 32'(out_first), 32'd1);
        ev_lo();
        chk("t1.popped", 32'(out_valid), 32'd0);
        ev_hi(16'h0025);
        chk("t2.stamp", 32'(out_stamp), 32'h0025);
        chk("t2.delta", 32'(out_delta), 32'h0015);
        chk("t2.first", 32'(out_first), 32'd0);
        ev_lo();

        // Wrap-around interval
        ev_hi(16'hFFFE); ev_lo();
        ev_hi(16'h0003);
        chk("wrap.delta", 32'(out_delta), 32'h0005);
        ev_lo();

        // Overflow: five events into a four-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev_hi(16'h0100 + 16'(i * 16'h11)); ev_lo();
        end
        chk("ovf.level", 32'(level), 32'd4);
        chk("ovf.flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf.order", 32'(out_stamp), 32'(16'h0100 + 16'(i * 16'h11)));
            step();
        end
        chk("ovf.drained", 32'(level), 32'd0);
        ev_hi(16'h0200);
        chk("ovf.delta6", 32'(out_delta), 32'h00BC);
        ev_lo();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf.clr", 32'(overflow), 32'd0);

        // Full FIFO, event concurrent with pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev_hi(16'h0300 + 16'(i)); ev_lo();
        end
        chk("fp.full", 32'(level), 32'd4);
        out_ready = 1'b1;
        ev_hi(16'h0400);
        chk("fp.level", 32'(level), 32'd4);
        chk("fp.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) ev_lo();
        chk("fp.empty", 32'(level), 32'd0);

        // Event level held high counts once
        out_ready = 1'b0;
        event_in = 1'b1; count = 16'h0500;
        repeat (10) step();
        event_in = 1'b0; step();
        chk("hold.level", 32'(level), 32'd1);
        out_ready = 1'b1; step();

        // Disarmed events ignored, re-arm restarts with first=1
        enable = 1'b0; out_ready = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            ev_hi(16'h0600 + 16'(i)); ev_lo();
        end
        chk("dis.level", 32'(level), 32'd0);
        enable = 1'b1; step();
        ev_hi(16'h0777);
        chk("rearm.first", 32'(out_first), 32'd1);
        chk("rearm.delta", 32'(out_delta), 32'd0);
        ev_lo();
        out_ready = 1'b1; step(); step();

        // Asynchronous reset mid-burst
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev_hi(16'h0800 + 16'(i * 3)); ev_lo();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("mid.level", 32'(level), 32'd3);
        chk("mid.ovf", 32'(overflow), 32'd1);
        reset = 1'b0; model_reset();
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.level", 32'(level), 32'd0);
        chk("arst.ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ev_hi(16'h0900);
        chk("post.drop", 32'(level), 32'd0);
        ev_lo();
        ev_hi(16'h0905);
        chk("post.level", 32'(level), 32'd1);
        chk("post.first", 32'(out_first), 32'd1);
        ev_lo();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            event_in  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 15) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            count     = count + 16'($urandom_range(1, 3000));
            step();
        end
        event_in = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        repeat (D + 1) step();
        chk("end.empty", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Downstream consumer of a free-running 16-bit up counter's `count` bus.
- On each rising edge of a synchronous event strobe, captures the current count as a timestamp and computes the modular interval since the previous event.
- Buffers {stamp, delta, first} entries in a small FIFO, drained over a valid/ready interface.
- Used for period and pulse-spacing measurement in the counters benchmark set.

Parameters:
- WIDTH, 16: width of `count`, stamp and delta.
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- LVLW, 3: width of `level`. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-low reset.
- count  input  WIDTH  counter value, synchronous to clk.
- enable  input  1  arm capture; low disarms.
- event_in  input  1  synchronous event level; a 0->1 transition is an event.
- ovf_clr  input  1  single-cycle pulse that clears `overflow`.
- out_valid  output  1  FIFO head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_stamp  output  WIDTH  captured count of the head entry.
- out_delta  output  WIDTH  interval of the head entry.
- out_first  output  1  head entry is the first event since arming.
- level  output  LVLW  number of entries held, 0..DEPTH.
- overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO empty, `level`=0, `out_valid`=0.
  - `out_stamp`/`out_delta`=0, `out_first`=0, `overflow`=0.
  - Edge-detect register=0, last_stamp=0, state=DISARMED.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Edge detect:
  - `ev_prev` registers `event_in` every cycle.
  - An event fires in cycle t when event_in(t)==1 and ev_prev(t)==0.
  - The stamp is `count` sampled in cycle t.
  - The entry is visible on outputs at t+1 at the earliest (1-cycle latency if the FIFO was empty).
- State machine (state registered):
  - DISARMED: events ignored, `ev_prev` still tracks `event_in`. enable==1 -> ARMED.
  - ARMED: next event pushes {stamp, delta=0, first=1}, sets last_stamp=stamp -> RUNNING. enable==0 -> DISARMED.
  - RUNNING: each event pushes {stamp, delta=(stamp-last_stamp) mod 2^WIDTH, first=0} and updates last_stamp. enable==0 -> DISARMED.
  - An event in the same cycle as enable falling is still processed (state decision uses the current state).
  - Re-arming always restarts with first=1.
- Wrap-around: delta is unsigned subtraction truncated to WIDTH bits. Example: last=0xFFFE, stamp=0x0003 -> delta=0x0005. Two events at the same count value (exactly 2^WIDTH apart) give delta=0; this is accepted.
- FIFO:
  - Push on event when state is ARMED/RUNNING and (level<DEPTH or pop this cycle).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave `level` unchanged, including when full.
  - Outputs present the head entry. With out_valid==0, `out_stamp`/`out_delta`/`out_first` hold their last values and are don't-care.
  - Entries are never reordered or duplicated.
  - out_ready while empty has no effect.
- Overflow:
  - An event while full and not popping is dropped and sets `overflow`=1.
  - last_stamp is still updated on a drop, so the next entry's delta measures from the dropped event.
  - ovf_clr clears `overflow`. If ovf_clr and a new drop occur in the same cycle, set wins.
- Disarm does not flush the FIFO; buffered entries remain drainable.

Test Plan:
- Reset release, enable=1, out_ready=1, events when count=0x0010 and 0x0025 -> entries {0x0010, 0x0000, first=1} then {0x0025, 0x0015, 0}; out_valid high exactly 1 cycle after each event.
- Wrap: events at count=0xFFFE and 0x0003 -> second entry delta=0x0005.
- out_ready=0, 5 events with DEPTH=4 -> level=4, overflow=1 after the 5th. Drain returns the first 4 stamps in order. A 6th event after draining has delta measured from the 5th (dropped) event. ovf_clr pulse -> overflow=0.
- Full FIFO, event in the same cycle as a pop -> push accepted, level stays 4, overflow stays 0.
- event_in held high 10 cycles -> exactly one entry. enable=0 during events -> no entries. Re-enable then event -> first=1, delta=0.
- Assert reset mid-burst with 3 entries buffered -> out_valid=0, level=0, overflow=0 asynchronously. After release, the first event is dropped (state DISARMED) until enable is seen.
